// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed combinationally at accept time and held in shadow
// registers; a down-counter delays their commit to HI/LO so the pipeline
// sees a fixed MUL_CYCLES / DIV_CYCLES latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight, start/op accepted
// ST_BUSY | mul/div in flight, counter running, commit at terminal count

module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_RAW = $clog2(MAX_CYC);
    localparam int CNT_W   = (CNT_RAW < 4) ? 4 : ((CNT_RAW > 8) ? 8 : CNT_RAW);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        sh_hi;
    logic [31:0]        sh_lo;
    logic               sh_valid;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               b_zero;
    logic               div_ovf;

    // Arithmetic results for the operands presented this cycle; the
    // most-negative / -1 case is pinned so it never relies on overflow behaviour.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'b0, A} * {32'b0, B};
        b_zero  = (B == 32'd0);
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        quot_s  = '0;
        rem_s   = '0;
        quot_u  = '0;
        rem_u   = '0;
        if (!b_zero) begin
            quot_u = A / B;
            rem_u  = A % B;
            if (div_ovf) begin
                quot_s = 32'sh8000_0000;
                rem_s  = '0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
        end
    end

    // Accept, count down and commit; busy and HI/LO are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            sh_hi    <= '0;
            sh_lo    <= '0;
            sh_valid <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                {sh_hi, sh_lo} <= prod_s;
                                sh_valid       <= 1'b1;
                                cnt            <= MUL_LOAD;
                                busy           <= 1'b1;
                                state          <= ST_BUSY;
                            end
                            OP_MULTU: begin
                                {sh_hi, sh_lo} <= prod_u;
                                sh_valid       <= 1'b1;
                                cnt            <= MUL_LOAD;
                                busy           <= 1'b1;
                                state          <= ST_BUSY;
                            end
                            OP_DIV: begin
                                sh_hi    <= rem_s;
                                sh_lo    <= quot_s;
                                sh_valid <= !b_zero;
                                cnt      <= DIV_LOAD;
                                busy     <= 1'b1;
                                state    <= ST_BUSY;
                            end
                            OP_DIVU: begin
                                sh_hi    <= rem_u;
                                sh_lo    <= quot_u;
                                sh_valid <= !b_zero;
                                cnt      <= DIV_LOAD;
                                busy     <= 1'b1;
                                state    <= ST_BUSY;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        if (sh_valid) begin
                            hi <= sh_hi;
                            lo <= sh_lo;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // mfhi/mflo read path.
    always_comb begin
        md_out = rd_hi ? hi : lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a cycle-level behavioural model of HI/LO and the
// busy window, compared against the DUT every falling edge, plus directed
// vectors with hand-computed literal results.

module tb_mul_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .rd_hi  (rd_hi),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: remaining busy cycles and the pending result.
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    logic        m_pend_ok;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0;
            m_pend_hi = 0; m_pend_lo = 0; m_pend_ok = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pend_ok) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (start) begin
            longint sa, sb, q, r;
            logic [63:0] p;
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            case (op)
                3'd1: begin
                    p = 64'(sa * sb);
                    {m_pend_hi, m_pend_lo} = p; m_pend_ok = 1; m_left = MUL_N;
                end
                3'd2: begin
                    p = {32'b0, A} * {32'b0, B};
                    {m_pend_hi, m_pend_lo} = p; m_pend_ok = 1; m_left = MUL_N;
                end
                3'd3: begin
                    m_left = DIV_N; m_pend_ok = (B != 0);
                    if (B != 0) begin
                        q = sa / sb;
                        r = sa - q * sb;
                        m_pend_lo = q[31:0]; m_pend_hi = r[31:0];
                    end
                end
                3'd4: begin
                    m_left = DIV_N; m_pend_ok = (B != 0);
                    if (B != 0) begin
                        m_pend_lo = A / B; m_pend_hi = A % B;
                    end
                end
                3'd5: m_hi = A;
                3'd6: m_lo = A;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("md_out", md_out, rd_hi ? m_hi : m_lo);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0; A = 32'h1234_5678; B = 32'h0000_0009;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_hi = 1'b0;
        idle(3);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;
        idle(2);

        // 1: reset mid-MULT aborts it
        issue(3'd1, 32'd5, 32'd7);
        idle(1);
        chk("t1_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t1_busy_async", {31'b0, busy}, 32'd0);
        chk("t1_hi_async", hi, 32'd0);
        chk("t1_lo_async", lo, 32'd0);
        idle(1);
        reset = 1'b1;
        idle(8);
        chk("t1_no_commit_lo", lo, 32'd0);

        // 2: MULT -2 * 3, commit exactly MUL_N edges later
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MUL_N - 1);
        chk("t2_busy_last", {31'b0, busy}, 32'd1);
        chk("t2_lo_old", lo, 32'd0);
        idle(1);
        chk("t2_busy_done", {31'b0, busy}, 32'd0);
        chk("t2_hi", hi, 32'hFFFF_FFFF);
        chk("t2_lo", lo, 32'hFFFF_FFFA);

        // 3: MULTU, DIV, DIV overflow, DIVU, signed MULT of negatives
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MUL_N);
        chk("t3_multu_hi", hi, 32'h0000_0001);
        chk("t3_multu_lo", lo, 32'hFFFF_FFFE);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N - 1);
        chk("t3_div_busy", {31'b0, busy}, 32'd1);
        idle(1);
        chk("t3_div_lo", lo, 32'hFFFF_FFFD);
        chk("t3_div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        chk("t3_ovf_lo", lo, 32'h8000_0000);
        chk("t3_ovf_hi", hi, 32'h0000_0000);
        issue(3'd4, 32'd100, 32'd7);
        idle(DIV_N);
        chk("t3_divu_lo", lo, 32'd14);
        chk("t3_divu_hi", hi, 32'd2);
        issue(3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        idle(MUL_N);
        chk("t3_mult_neg_lo", lo, 32'd12);
        chk("t3_mult_neg_hi", hi, 32'd0);
        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        idle(DIV_N);
        chk("t3_div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("t3_div_negb_hi", hi, 32'd1);

        // 4: DIVU by zero leaves HI/LO alone
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        issue(3'd4, 32'd100, 32'd0);
        idle(DIV_N - 1);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        idle(1);
        chk("t4_busy_done", {31'b0, busy}, 32'd0);
        chk("t4_hi", hi, 32'h11);
        chk("t4_lo", lo, 32'h22);

        // 5: starts during busy (including the falling edge) are ignored
        issue(3'd1, 32'd6, 32'd7);
        issue(3'd5, 32'h0000_AAAA, 32'd0);
        idle(MUL_N - 2);
        issue(3'd6, 32'h0000_5555, 32'd0);
        chk("t5_busy_done", {31'b0, busy}, 32'd0);
        chk("t5_hi", hi, 32'd0);
        chk("t5_lo", lo, 32'd42);

        // ops 0 and 7 with start change nothing
        issue(3'd0, 32'hAAAA_AAAA, 32'd1);
        issue(3'd7, 32'hBBBB_BBBB, 32'd1);
        chk("t5_nop_hi", hi, 32'd0);
        chk("t5_nop_lo", lo, 32'd42);

        // 6: MTLO visible on md_out next cycle, never busy
        rd_hi = 1'b0;
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        chk("t6_md_out_lo", md_out, 32'hDEAD_BEEF);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        rd_hi = 1'b1;
        #1;
        chk("t6_md_out_hi", md_out, 32'd0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
